// File: rtl/axi_wr_ctrl.sv
// axi_wr_ctrl: single-outstanding AXI write slave turning INCR bursts into one-cycle memory write strobes
module axi_wr_ctrl #(
  parameter int ID_WIDTH = 4,
  localparam int ADDR_WIDTH = 12,
  localparam int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb
);
  typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;
  state_t state, state_nxt;
  logic rdy_en, err, slv, aw_fire, w_fire, at_end, aw_err;
  logic [ID_WIDTH-1:0] id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0] len, cnt;
  logic [12:0] aw_end;
  assign o_awready = rdy_en && state == IDLE;
  assign o_wready = state == DATA || state == DRAIN;
  assign o_bvalid = state == RESP;
  assign o_bid = id;
  assign o_bresp = {slv, 1'b0};
  assign aw_fire = o_awready && i_awvalid;
  assign w_fire = o_wready && i_wvalid;
  assign at_end = cnt == len;
  // burst end computed in 13 bits so a burst ending exactly at 4 KiB is legal and one past is caught
  assign aw_end = {1'b0, i_awaddr} + {1'b0, {2'b0, i_awlen} + 10'd1, 2'b00};
  assign aw_err = i_awburst != 2'b01 || i_awsize != 3'd2 || i_awaddr[1:0] != 2'b00 || aw_end > 13'd4096;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = aw_fire ? DATA : IDLE;
      DATA:  state_nxt = !w_fire ? DATA : i_wlast ? RESP : at_end ? DRAIN : DATA;
      DRAIN: state_nxt = w_fire && i_wlast ? RESP : DRAIN;
      RESP:  state_nxt = i_bready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rdy_en <= 1'b0;
      id <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      err <= 1'b0;
      slv <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      state <= state_nxt;
      rdy_en <= 1'b1;
      o_mem_we <= 1'b0;
      if (aw_fire) begin
        id <= i_awid;
        addr <= i_awaddr;
        len <= i_awlen;
        cnt <= '0;
        err <= aw_err;
        slv <= aw_err;
      end
      if (w_fire && state == DATA) begin
        o_mem_we <= !err;
        o_mem_addr <= addr;
        o_mem_wdata <= i_wdata;
        o_mem_wstrb <= i_wstrb;
        if (!at_end) begin
          cnt <= cnt + 8'd1;
          addr <= addr + 12'd4;
        end
        // early wlast or missing wlast on the final beat
        if (at_end != i_wlast) slv <= 1'b1;
      end
    end
  end
endmodule

// File: doc/axi_wr_ctrl.md
AXI_WR_CTRL -- requirements
Module: axi_wr_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, width of AXI write transaction ID.
REQ-002 SHALL fix ADDR_WIDTH=12 and DATA_WIDTH=32 as non-overridable localparams; beat increment 4 bytes, expected awsize 3'd2.
REQ-003 SHALL use one clock and an asynchronous active-low reset, ports as follows:
  clk  in  1  rising-edge clock
  reset_n  in  1  asynchronous active-low reset
  i_awid  in  ID_WIDTH  AW transaction ID
  i_awaddr  in  12  AW byte start address
  i_awlen  in  8  beats minus one
  i_awsize  in  3  beat size
  i_awburst  in  2  burst type
  i_awvalid / o_awready  in/out  1  AW handshake
  i_wdata  in  32  write data
  i_wstrb  in  4  byte strobes
  i_wlast  in  1  last-beat marker
  i_wvalid / o_wready  in/out  1  W handshake
  o_bid  out  ID_WIDTH  response ID
  o_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
  o_bvalid / i_bready  out/in  1  B handshake
  o_mem_we  out  1  one-cycle memory write strobe
  o_mem_addr  out  12  memory byte address
  o_mem_wdata  out  32  memory write data
  o_mem_wstrb  out  4  memory byte enables

Function
REQ-004 SHALL implement states IDLE, DATA, DRAIN, RESP; one burst outstanding at a time.
REQ-005 SHALL drive o_awready=1 only in IDLE and only from the first clock after reset_n deasserts (registered ready-enable flag); o_wready=1 only in DATA or DRAIN; o_bvalid=1 only in RESP.
REQ-006 On AW handshake in IDLE SHALL capture awid, awaddr, awlen, clear beat count, go to DATA next cycle.
REQ-007 SHALL flag burst error at AW capture if awburst!=2'b01, awsize!=3'd2, awaddr[1:0]!=0, or awaddr+(awlen+1)*4 > 4096 (13-bit arithmetic, no truncation).
REQ-008 In DATA, each W handshake SHALL register o_mem_we=1 (if no burst error), o_mem_addr=current address, o_mem_wdata=i_wdata, o_mem_wstrb=i_wstrb, visible exactly one cycle after the handshake; o_mem_we=0 on all other cycles.
REQ-009 Current address SHALL increment by 4 per accepted W beat, beat count by 1 (8-bit, never exceeds awlen).
REQ-010 W beat with count==awlen and i_wlast=1 SHALL go to RESP.
REQ-011 W beat with count<awlen and i_wlast=1 (early last) SHALL be written, set SLVERR, go to RESP.
REQ-012 W beat with count==awlen and i_wlast=0 SHALL be written, set SLVERR, go to DRAIN.
REQ-013 In DRAIN SHALL accept W beats without memory writes until a beat with i_wlast=1, then go to RESP.
REQ-014 In RESP SHALL hold o_bvalid, o_bid=captured id, o_bresp=SLVERR if any error else OKAY, stable until i_bready; on handshake go to IDLE next cycle.
REQ-015 Burst with error flag SHALL accept all W beats (same wlast rules) but issue no o_mem_we.
REQ-016 Minimum AW-to-AW spacing: AW accept cycle N, first W accept N+1, B valid cycle after last W, next AW accept cycle after B handshake.
REQ-017 W handshakes in IDLE or RESP SHALL not occur (o_wready=0); i_wvalid there is ignored.

Reset
REQ-018 reset_n low SHALL asynchronously force state IDLE; o_awready, o_wready, o_bvalid, o_mem_we =0; o_mem_addr, o_mem_wdata, o_mem_wstrb, o_bid, o_bresp, counters, error flag =0.
REQ-019 Reset mid-burst SHALL abandon burst with no B response and no further memory writes.

Verification
REQ-020 AW addr 0x100 len 3 size 2 INCR, 4 W beats wlast on 4th, bready=1 -> writes 0x100,0x104,0x108,0x10C, B OKAY with captured id.
REQ-021 AW addr 0xFF8 len 3 -> 4 W beats accepted, zero o_mem_we, B SLVERR.
REQ-022 AW len 3, wlast on beat 2 -> 2 writes, B SLVERR, back to IDLE, next AW accepted.
REQ-023 AW len 1, wlast absent on beat 2, beat 3 with wlast -> 2 writes, beat 3 discarded, B SLVERR.
REQ-024 Random wvalid gaps and bready held low 5 cycles -> write order/addresses unchanged, o_bvalid/o_bid/o_bresp stable, o_awready=0 until B handshake.
REQ-025 reset_n pulsed low during DATA beat 2 of len 7 -> all outputs 0 immediately, o_awready=1 one cycle after release, new burst completes OKAY.
